cook_time_entry: RTL

Front-panel input stage of the microwave simulator. It sits directly upstream of `timer`. It debounces the five raw Nexys A7 push-buttons, lets the user dial a cook time, and tracks the oven operating state. It drives the `min`, `sec`, `start`, `pause` and `stop` inputs of `timer`, and consumes that block's `done` flag.

---
 rtl/microwave_pkg.sv | 15 +
 rtl/btn_debounce.sv | 69 ++++++
 rtl/cook_time_entry.sv | 116 +++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: oven state encoding
// and time-field limits.
// Ports: none (package).
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int SEC_MAX         = 59;
  localparam int MAX_MIN_DEFAULT = 99;

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button to one single-cycle press event: 2-FF synchronizer,
// stability filter, registered rising-edge detect.
// Ports: clock, reset (async active-low), btn (raw, async), press (event pulse).
// Latency: DEBOUNCE_CYCLES+3 edges with COOK_DEBOUNCE_EN defined, 3 edges without
// (filter bypassed, DEBOUNCE_CYCLES unused).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef COOK_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          stable;

  // Count consecutive cycles that the synchronized level differs from the
  // accepted level; any return to the accepted level restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = stable;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/cook_time_entry.sv
// Microwave front panel: debounced buttons, cook-time entry and oven state,
// driving start/pause/stop pulses and min/sec to the downstream timer.
// Ports: clock, reset (async active-low), btn_start/pause/stop/min_inc/sec_inc
// (raw buttons), done (from timer); start/pause/stop (1-cycle pulses), min, sec, busy.
// Build macro: COOK_DEBOUNCE_EN enables the debounce filter inside btn_debounce.
module cook_time_entry
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_MIN         = MAX_MIN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_stop,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic       stop,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       busy
);

  localparam logic [6:0] MIN_TOP = 7'(MAX_MIN);
  localparam logic [6:0] SEC_TOP = 7'(SEC_MAX);

  logic [4:0] raw;
  logic [4:0] ev;
  assign raw = {btn_sec_inc, btn_min_inc, btn_stop, btn_pause, btn_start};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clock (clock),
      .reset (reset),
      .btn   (raw[i]),
      .press (ev[i])
    );
  end

  logic ev_start, ev_pause, ev_stop, ev_min_inc, ev_sec_inc;
  assign {ev_sec_inc, ev_min_inc, ev_stop, ev_pause, ev_start} = ev;

  state_t     state, state_nx;
  logic       start_nx, pause_nx, stop_nx;
  logic [6:0] min_nx, sec_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Single priority chain: only the highest-priority event acts each cycle.
  // done counts only while running; elsewhere it never masks other events.
  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    pause_nx = 1'b0;
    stop_nx  = 1'b0;
    min_nx   = min;
    sec_nx   = sec;
    if (done && state == RUN) begin
      state_nx = IDLE;
      min_nx   = '0;
      sec_nx   = '0;
    end else if (ev_stop) begin
      stop_nx  = (state != IDLE);
      state_nx = IDLE;
      min_nx   = '0;
      sec_nx   = '0;
    end else if (ev_start) begin
      if (state == PAUSED || (state == IDLE && (min != '0 || sec != '0))) begin
        state_nx = RUN;
        start_nx = 1'b1;
      end
    end else if (ev_pause) begin
      if (state == RUN) begin
        state_nx = PAUSED;
        pause_nx = 1'b1;
      end
    end else if (ev_sec_inc) begin
      if (state == IDLE) begin
        if (sec != SEC_TOP) begin
          sec_nx = sec + 7'd1;
        end else if (min != MIN_TOP) begin
          sec_nx = '0;
          min_nx = min + 7'd1;
        end
      end
    end else if (ev_min_inc) begin
      if (state == IDLE && min != MIN_TOP) min_nx = min + 7'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start <= 1'b0;
      pause <= 1'b0;
      stop  <= 1'b0;
      min   <= '0;
      sec   <= '0;
      busy  <= 1'b0;
    end else begin
      start <= start_nx;
      pause <= pause_nx;
      stop  <= stop_nx;
      min   <= min_nx;
      sec   <= sec_nx;
      busy  <= (state_nx != IDLE);
    end
  end

endmodule
